management_mdio_arbiter: RTL and testbench
==========================================

# management_mdio_arbiter

Shares the single MDIO transceiver in the management subsystem between two requesters: the register interface (software PHY access) and an autonomous link-status poller. The poller periodically reads PHY BMSR and publishes link state without software involvement. Sits between the management register interface and the MDIO transceiver's register port, on the system clock.

## Interface
Parameters:
- POLL_INTERVAL, 25000000: cycles between poll issues (100 ms at 250 MHz); minimum 16.
- POLL_REG, 5'h01: PHY register read by the poller (BMSR).
- LINK_BIT, 2: bit of POLL_REG giving link status.

Ports:
- clk  in  1  system clock; sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- poll_en  in  1  enables poll timer.
- host_reg_addr  in  5  register address, sampled with strobe.
- host_wr_data  in  16  write data, sampled with strobe.
- host_reg_wr / host_reg_rd  in  1  single-cycle request strobes.
- host_busy  out  1  host transaction pending or in flight.
- host_rd_data  out  16  last host read result.
- phy_reg_addr  out  5  to transceiver.
- phy_wr_data  out  16  to transceiver.
- phy_reg_wr / phy_reg_rd  out  1  single-cycle strobes to transceiver.
- phy_busy  in  1  transceiver busy.
- phy_rd_data  in  16  transceiver read data, valid on busy fall.
- link_up  out  1  last polled LINK_BIT.
- link_valid  out  1  at least one poll completed since reset/poll_en rise.
- link_change  out  1  one-cycle pulse when link_up toggles.

## Operation
- States: RESYNC, IDLE, ISSUE, WAIT_START, WAIT_DONE.
- RESYNC (reset state): wait for phy_busy low (transaction may survive our reset), then IDLE.
- Host strobe in any state: latch addr/data/direction into one-deep host slot, set host_pending. Strobe while host_busy high is dropped (software must poll busy). Both strobes at once: treated as read.
- Poll timer: counts while poll_en; at POLL_INTERVAL-1 sets poll_pending, wraps to 0. poll_en low clears counter, poll_pending, link_valid; in-flight poll completes but its result is discarded.
- IDLE: host_pending wins over poll_pending; chosen request -> ISSUE.
- ISSUE: drive phy_reg_addr/phy_wr_data, pulse phy_reg_wr or phy_reg_rd one cycle, clear the matching pending flag -> WAIT_START.
- WAIT_START: phy_busy high -> WAIT_DONE; 8 cycles without busy -> IDLE (transaction treated as complete, no data captured).
- WAIT_DONE: phy_busy falls -> capture phy_rd_data into host_rd_data (host read) or LINK_BIT into link_up (poll), -> IDLE.
- Poll reads never modify host_rd_data; host reads never modify link_up.
- link_change pulses only when link_valid already set and new value differs; first poll sets link_valid without pulse.
- host_busy = strobe | host_pending | host transaction active (combinational on strobe, so no gap visible).

## Timing
- Reset values: all outputs 0; host_rd_data 16'h0; phy_reg_addr 0.
- Host strobe in IDLE, no conflict: phy strobe 2 cycles later (latch, ISSUE).
- Poll expiry coincident with host strobe: host served first, poll next.
- Poll expiry while poll_pending already set: merged (no queue).
- host_busy falls the cycle after phy_busy falls; host_rd_data valid same cycle.
- link_up/link_change update cycle after phy_busy falls.
- Worst-case host latency: one full poll transaction plus 2 cycles.

## Structure
- Package mgmt_mdio_pkg: state enum, WAIT_START_TIMEOUT (8), BMSR address/bit constants.
- Sub-module mdio_poll_timer: counter plus poll_pending generation, width $clog2(POLL_INTERVAL).

## Test plan
- Reset with phy_busy held high 20 cycles -> no phy strobe until busy low; all outputs 0.
- Host read addr 5'h02, model returns 16'h0141 -> one phy_reg_rd with addr 2, host_rd_data=16'h0141, host_busy low after busy fall.
- POLL_INTERVAL=100, poll_en=1, model BMSR 16'h0004 then 16'h0000 -> poll every 100 cycles at addr 1; link_valid on first, link_up 1 then 0, single link_change pulse.
- Host write 5'h00/16'h8000 strobed same cycle as poll expiry -> phy_reg_wr issued first, poll read follows; host_rd_data unchanged by poll.
- Second host strobe during host_busy -> dropped, exactly one phy strobe.
- Model never asserts busy -> return to IDLE after 8 cycles; host_busy clears; next request serviced.

Source files
------------

// File: rtl/mgmt_mdio_pkg.sv
// Shared types and constants for the MDIO arbiter that shares one transceiver
// between host register accesses and the link-status poller.
package mgmt_mdio_pkg;

    typedef enum logic [2:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } arb_state_t;

    localparam int         WAIT_START_TIMEOUT = 8;
    localparam logic [4:0] BMSR_ADDR          = 5'h01;
    localparam int         BMSR_LINK_BIT      = 2;

endpackage

// File: rtl/mdio_poll_timer.sv
// Free-running poll interval counter; raises a sticky poll request on each wrap.
// Back-to-back expiries merge into the single pending flag.
module mdio_poll_timer #(
    parameter int POLL_INTERVAL = 25000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_poll_en,
    input  logic i_clear,
    output logic o_poll_pending
);

    localparam int CW = $clog2(POLL_INTERVAL);

    logic [CW-1:0] r_cnt;
    logic          r_pending;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_poll_en) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else if (r_cnt == CW'(POLL_INTERVAL - 1)) begin
            // A fresh expiry wins over a same-cycle clear from the arbiter.
            r_cnt     <= '0;
            r_pending <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (i_clear) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_poll_pending = r_pending;

endmodule

// File: rtl/management_mdio_arbiter.sv
// Arbitrates the MDIO transceiver register port between a one-deep host slot
// and the periodic BMSR poller, publishing link state from the poll results.
module management_mdio_arbiter
    import mgmt_mdio_pkg::*;
#(
    parameter int         POLL_INTERVAL = 25000000,
    parameter logic [4:0] POLL_REG      = BMSR_ADDR,
    parameter int         LINK_BIT      = BMSR_LINK_BIT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_poll_en,
    input  logic [4:0]  i_host_reg_addr,
    input  logic [15:0] i_host_wr_data,
    input  logic        i_host_reg_wr,
    input  logic        i_host_reg_rd,
    output logic        o_host_busy,
    output logic [15:0] o_host_rd_data,
    output logic [4:0]  o_phy_reg_addr,
    output logic [15:0] o_phy_wr_data,
    output logic        o_phy_reg_wr,
    output logic        o_phy_reg_rd,
    input  logic        i_phy_busy,
    input  logic [15:0] i_phy_rd_data,
    output logic        o_link_up,
    output logic        o_link_valid,
    output logic        o_link_change
);

    localparam int WS_W = $clog2(WAIT_START_TIMEOUT);

    arb_state_t  r_state, w_state_next;

    logic        r_host_pending, r_host_active, r_host_rd;
    logic [4:0]  r_host_addr;
    logic [15:0] r_host_data;
    logic        r_cur_host, r_cur_rd, r_poll_discard;
    logic [WS_W-1:0] r_ws_cnt;
    logic [4:0]  r_phy_addr;
    logic [15:0] r_phy_data;
    logic [15:0] r_host_rd_data;
    logic        r_link_up, r_link_valid, r_link_change;

    logic w_host_strobe, w_host_accept, w_poll_pending, w_poll_clear;
    logic w_grant_host, w_grant_poll, w_capture, w_timeout, w_phy_wr, w_phy_rd;
    logic w_link_bit;

    assign w_host_strobe = i_host_reg_wr | i_host_reg_rd;
    assign w_host_accept = w_host_strobe & ~(r_host_pending | r_host_active);
    assign w_link_bit    = i_phy_rd_data[LINK_BIT];

    mdio_poll_timer #(
        .POLL_INTERVAL (POLL_INTERVAL)
    ) u_poll_timer (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_poll_en      (i_poll_en),
        .i_clear        (w_poll_clear),
        .o_poll_pending (w_poll_pending)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_RESYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_host = 1'b0;
        w_grant_poll = 1'b0;
        w_phy_wr     = 1'b0;
        w_phy_rd     = 1'b0;
        w_poll_clear = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_RESYNC: begin
                if (!i_phy_busy) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (r_host_pending) begin
                    w_grant_host = 1'b1;
                    w_state_next = ST_ISSUE;
                end else if (w_poll_pending) begin
                    w_grant_poll = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_phy_rd     = r_cur_rd;
                w_phy_wr     = ~r_cur_rd;
                w_poll_clear = ~r_cur_host;
                w_state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (i_phy_busy) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (r_ws_cnt == WS_W'(WAIT_START_TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_phy_busy) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_RESYNC;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_host_pending <= 1'b0;
            r_host_active  <= 1'b0;
            r_host_rd      <= 1'b0;
            r_host_addr    <= '0;
            r_host_data    <= '0;
            r_cur_host     <= 1'b0;
            r_cur_rd       <= 1'b0;
            r_poll_discard <= 1'b0;
            r_ws_cnt       <= '0;
            r_phy_addr     <= '0;
            r_phy_data     <= '0;
        end else begin
            if (w_host_accept) begin
                r_host_pending <= 1'b1;
                r_host_addr    <= i_host_reg_addr;
                r_host_data    <= i_host_wr_data;
                r_host_rd      <= i_host_reg_rd;
            end
            // Pending hands over to active on the same edge so host_busy never dips.
            if (r_state == ST_ISSUE && r_cur_host) begin
                r_host_pending <= 1'b0;
                r_host_active  <= 1'b1;
            end
            if ((w_capture || w_timeout) && r_cur_host) begin
                r_host_active <= 1'b0;
            end
            if (w_grant_host) begin
                r_cur_host <= 1'b1;
                r_cur_rd   <= r_host_rd;
                r_phy_addr <= r_host_addr;
                r_phy_data <= r_host_data;
            end
            if (w_grant_poll) begin
                r_cur_host     <= 1'b0;
                r_cur_rd       <= 1'b1;
                r_phy_addr     <= POLL_REG;
                r_phy_data     <= '0;
                r_poll_discard <= 1'b0;
            end
            if (!i_poll_en) begin
                r_poll_discard <= 1'b1;
            end
            r_ws_cnt <= (r_state == ST_WAIT_START) ? r_ws_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_host_rd_data <= '0;
            r_link_up      <= 1'b0;
            r_link_valid   <= 1'b0;
            r_link_change  <= 1'b0;
        end else begin
            r_link_change <= 1'b0;
            if (w_capture && r_cur_host && r_cur_rd) begin
                r_host_rd_data <= i_phy_rd_data;
            end
            if (w_capture && !r_cur_host && !r_poll_discard && i_poll_en) begin
                r_link_up    <= w_link_bit;
                r_link_valid <= 1'b1;
                if (r_link_valid && (w_link_bit != r_link_up)) begin
                    r_link_change <= 1'b1;
                end
            end
            if (!i_poll_en) begin
                r_link_valid <= 1'b0;
            end
        end
    end

    assign o_host_busy    = w_host_strobe | r_host_pending | r_host_active;
    assign o_host_rd_data = r_host_rd_data;
    assign o_phy_reg_addr = r_phy_addr;
    assign o_phy_wr_data  = r_phy_data;
    assign o_phy_reg_wr   = w_phy_wr;
    assign o_phy_reg_rd   = w_phy_rd;
    assign o_link_up      = r_link_up;
    assign o_link_valid   = r_link_valid;
    assign o_link_change  = r_link_change;

endmodule

// File: tb/tb_management_mdio_arbiter.sv
// Directed bench for management_mdio_arbiter: vector table of host accesses plus
// hand-written reset, drop, timeout and poll/priority sequences against a PHY model.
module tb_management_mdio_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        poll_en;
    logic [4:0]  host_reg_addr;
    logic [15:0] host_wr_data;
    logic        host_reg_wr, host_reg_rd;
    logic        host_busy;
    logic [15:0] host_rd_data;
    logic [4:0]  phy_reg_addr;
    logic [15:0] phy_wr_data;
    logic        phy_reg_wr, phy_reg_rd;
    logic        phy_busy;
    logic [15:0] phy_rd_data;
    logic        link_up, link_valid, link_change;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // PHY model state
    logic        hold_busy;
    logic        m_silent;
    logic        m_busy;
    logic [15:0] m_data;
    logic [15:0] m_bmsr;
    logic [15:0] m_host_data;
    int          m_cnt;
    int          m_n;
    int          fall_cyc;
    int          chg_n;
    int          chg_cyc;
    logic [4:0]  log_addr [64];
    logic        log_rd   [64];
    logic [15:0] log_wd   [64];
    int          log_cyc  [64];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] model_data;
        logic [15:0] exp_rd_data;
        logic        exp_rd_op;
    } vec_t;
    vec_t vt [5];

    management_mdio_arbiter #(
        .POLL_INTERVAL (100),
        .POLL_REG      (5'h01),
        .LINK_BIT      (2)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_poll_en       (poll_en),
        .i_host_reg_addr (host_reg_addr),
        .i_host_wr_data  (host_wr_data),
        .i_host_reg_wr   (host_reg_wr),
        .i_host_reg_rd   (host_reg_rd),
        .o_host_busy     (host_busy),
        .o_host_rd_data  (host_rd_data),
        .o_phy_reg_addr  (phy_reg_addr),
        .o_phy_wr_data   (phy_wr_data),
        .o_phy_reg_wr    (phy_reg_wr),
        .o_phy_reg_rd    (phy_reg_rd),
        .i_phy_busy      (phy_busy),
        .i_phy_rd_data   (phy_rd_data),
        .o_link_up       (link_up),
        .o_link_valid    (link_valid),
        .o_link_change   (link_change)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign phy_busy    = m_busy | hold_busy;
    assign phy_rd_data = m_data;

    // Transceiver model: busy rises 2 cycles after a strobe and lasts 10 cycles.
    always @(negedge clk) begin
        if (phy_reg_rd || phy_reg_wr) begin
            if (m_n < 64) begin
                log_addr[m_n] = phy_reg_addr;
                log_rd[m_n]   = phy_reg_rd;
                log_wd[m_n]   = phy_wr_data;
                log_cyc[m_n]  = cyc;
            end
            m_n   = m_n + 1;
            m_data = (phy_reg_addr == 5'h01) ? m_bmsr : m_host_data;
            m_cnt = m_silent ? 0 : 1;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 13) begin
                m_cnt    = 0;
                fall_cyc = cyc;
            end
        end
        m_busy = (m_cnt >= 3);
        if (link_change) begin
            chg_n   = chg_n + 1;
            chg_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller is positioned just after a rising edge.
    task automatic host_req(input logic rd, input logic wr, input logic [4:0] a,
                            input logic [15:0] d, output int t0);
        host_reg_addr = a;
        host_wr_data  = d;
        host_reg_rd   = rd;
        host_reg_wr   = wr;
        t0 = cyc;
        #1 chk("busy_on_strobe", 32'(host_busy), 32'd1);
        @(posedge clk); #1;
        host_reg_rd = 1'b0;
        host_reg_wr = 1'b0;
    endtask

    task automatic wait_host_idle(input int budget, output int t);
        int k;
        k = 0;
        while (host_busy && k < budget) begin
            @(posedge clk); #1;
            k = k + 1;
        end
        t = cyc;
        chk("host_busy_clears", 32'(host_busy), 32'd0);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int k;
        k = 0;
        while (m_n < target && k < budget) begin
            @(posedge clk); #1;
            k = k + 1;
        end
        chk("phy_strobe_seen", 32'(m_n >= target), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t, n0, s1, s2, k;
        logic [15:0] held;

        vt[0] = '{1'b1, 1'b0, 5'h02, 16'h0000, 16'h0141, 16'h0141, 1'b1};
        vt[1] = '{1'b1, 1'b0, 5'h03, 16'h0000, 16'hABCD, 16'hABCD, 1'b1};
        vt[2] = '{1'b0, 1'b1, 5'h00, 16'h8000, 16'h5555, 16'hABCD, 1'b0};
        vt[3] = '{1'b1, 1'b1, 5'h04, 16'h1111, 16'h1234, 16'h1234, 1'b1};
        vt[4] = '{1'b1, 1'b0, 5'h1F, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1};

        rst_n = 1'b0; poll_en = 1'b0;
        host_reg_addr = '0; host_wr_data = '0; host_reg_wr = 1'b0; host_reg_rd = 1'b0;
        hold_busy = 1'b1; m_silent = 1'b0; m_busy = 1'b0; m_data = '0;
        m_bmsr = 16'h0004; m_host_data = 16'h0141;
        m_cnt = 0; m_n = 0; fall_cyc = 0; chg_n = 0; chg_cyc = 0;

        // Reset with the transceiver still busy from a previous transaction
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {host_busy, host_rd_data, phy_reg_addr, phy_wr_data, phy_reg_wr,
                              phy_reg_rd, link_up, link_valid, link_change}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        host_req(1'b1, 1'b0, 5'h02, 16'h0000, t0);
        repeat (20) @(posedge clk);
        #1;
        chk("resync_no_strobe", 32'(m_n), 32'd0);
        chk("resync_host_busy", 32'(host_busy), 32'd1);
        hold_busy = 1'b0;
        wait_host_idle(60, t);
        chk("resync_strobe_count", 32'(m_n), 32'd1);
        chk("resync_addr", 32'(log_addr[0]), 32'h02);
        chk("resync_is_read", 32'(log_rd[0]), 32'd1);
        chk("resync_rd_data", 32'(host_rd_data), 32'h0141);

        // Host access vector table
        for (int i = 0; i < 5; i++) begin
            m_host_data = vt[i].model_data;
            n0 = m_n;
            @(posedge clk); #1;
            host_req(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, t0);
            wait_host_idle(60, t);
            chk($sformatf("vec%0d_count", i), 32'(m_n), 32'(n0 + 1));
            chk($sformatf("vec%0d_addr", i), 32'(log_addr[n0]), 32'(vt[i].addr));
            chk($sformatf("vec%0d_op", i), 32'(log_rd[n0]), 32'(vt[i].exp_rd_op));
            if (!vt[i].exp_rd_op)
                chk($sformatf("vec%0d_wdata", i), 32'(log_wd[n0]), 32'(vt[i].wdata));
            chk($sformatf("vec%0d_latency", i), 32'(log_cyc[n0]), 32'(t0 + 2));
            chk($sformatf("vec%0d_busy_fall", i), 32'(t), 32'(fall_cyc + 1));
            chk($sformatf("vec%0d_rd_data", i), 32'(host_rd_data), 32'(vt[i].exp_rd_data));
        end

        // Second strobe while busy is dropped
        m_host_data = 16'h2222;
        n0 = m_n;
        @(posedge clk); #1;
        host_req(1'b1, 1'b0, 5'h06, 16'h0000, t0);
        host_req(1'b1, 1'b0, 5'h07, 16'h0000, t0);
        wait_host_idle(60, t);
        repeat (5) @(posedge clk);
        #1;
        chk("drop_count", 32'(m_n), 32'(n0 + 1));
        chk("drop_addr", 32'(log_addr[n0]), 32'h06);
        chk("drop_rd_data", 32'(host_rd_data), 32'h2222);

        // Transceiver never goes busy: 8-cycle timeout, then normal service
        m_silent = 1'b1;
        n0 = m_n;
        @(posedge clk); #1;
        host_req(1'b0, 1'b1, 5'h09, 16'h0077, t0);
        wait_host_idle(60, t);
        chk("timeout_count", 32'(m_n), 32'(n0 + 1));
        chk("timeout_release", 32'(t), 32'(log_cyc[n0] + 9));
        chk("timeout_rd_data_kept", 32'(host_rd_data), 32'h2222);
        m_silent = 1'b0;
        m_host_data = 16'h0BEE;
        @(posedge clk); #1;
        host_req(1'b1, 1'b0, 5'h05, 16'h0000, t0);
        wait_host_idle(60, t);
        chk("after_timeout_count", 32'(m_n), 32'(n0 + 2));
        chk("after_timeout_rd_data", 32'(host_rd_data), 32'h0BEE);
        held = 16'h0BEE;

        // Link poller: first poll sets link_valid without a change pulse
        m_bmsr = 16'h0004;
        n0 = m_n;
        @(posedge clk); #1;
        poll_en = 1'b1;
        wait_strobes(n0 + 1, 250);
        s1 = log_cyc[n0];
        chk("poll1_addr", 32'(log_addr[n0]), 32'h01);
        chk("poll1_is_read", 32'(log_rd[n0]), 32'd1);
        k = 0;
        while (!link_valid && k < 60) begin @(posedge clk); #1; k = k + 1; end
        chk("poll1_link_valid", 32'(link_valid), 32'd1);
        chk("poll1_link_up", 32'(link_up), 32'd1);
        chk("poll1_no_change", 32'(chg_n), 32'd0);
        chk("poll1_host_data_kept", 32'(host_rd_data), 32'(held));

        // Second poll drops the link and pulses link_change once
        m_bmsr = 16'h0000;
        wait_strobes(n0 + 2, 150);
        s2 = log_cyc[n0 + 1];
        chk("poll_interval", 32'(s2 - s1), 32'd100);
        k = 0;
        while (chg_n == 0 && k < 60) begin @(posedge clk); #1; k = k + 1; end
        chk("poll2_link_up", 32'(link_up), 32'd0);
        chk("poll2_change_count", 32'(chg_n), 32'd1);
        chk("poll2_change_timing", 32'(chg_cyc), 32'(fall_cyc + 1));

        // Host write strobed in the same cycle the poll timer expires
        n0 = m_n;
        while (cyc < s2 + 98) begin @(posedge clk); #1; end
        host_req(1'b0, 1'b1, 5'h00, 16'h8000, t0);
        wait_strobes(n0 + 2, 80);
        chk("coinc_first_is_write", 32'(log_rd[n0]), 32'd0);
        chk("coinc_first_addr", 32'(log_addr[n0]), 32'h00);
        chk("coinc_first_wdata", 32'(log_wd[n0]), 32'h8000);
        chk("coinc_first_time", 32'(log_cyc[n0]), 32'(s2 + 100));
        chk("coinc_second_is_read", 32'(log_rd[n0 + 1]), 32'd1);
        chk("coinc_second_addr", 32'(log_addr[n0 + 1]), 32'h01);
        repeat (20) @(posedge clk);
        #1;
        chk("coinc_host_data_kept", 32'(host_rd_data), 32'(held));
        chk("coinc_link_up", 32'(link_up), 32'd0);
        chk("coinc_change_count", 32'(chg_n), 32'd1);

        // Disabling the poller clears link_valid
        poll_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("poll_off_link_valid", 32'(link_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
